// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - status inputs and staged reset outputs of the reset sequencer
interface reset_sequencer_if;
   logic [1:0] pll_lock;
   logic       ddr_calib_done;
   logic       sw_rst_req;
   logic       sw_rst_ack;
   logic       ddr_rst_o;
   logic       periph_rst_o;
   logic       core_rst_o;
   logic [2:0] seq_state_o;
   logic       calib_fail_o;

   modport master (
      output pll_lock, ddr_calib_done, sw_rst_req,
      input  sw_rst_ack, ddr_rst_o, periph_rst_o, core_rst_o, seq_state_o, calib_fail_o
   );

   modport slave (
      input  pll_lock, ddr_calib_done, sw_rst_req,
      output sw_rst_ack, ddr_rst_o, periph_rst_o, core_rst_o, seq_state_o, calib_fail_o
   );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged PLL/DDR/peripheral/core reset release; RESET_SEQ_CALIB_TIMEOUT_EN adds calibration timeout/retry
module reset_sequencer #(
   parameter int HOLD_CYCLES   = 16,
   parameter int CALIB_TIMEOUT = 1000000,
   parameter int MAX_RETRY     = 3,
   parameter int CNT_W         = 20
) (
   input  logic             clk,
   input  logic             rstn,
   reset_sequencer_if.slave bus
);

`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
   typedef enum logic [2:0] {
      S_WAIT_LOCK   = 3'd0,
      S_HOLD_DDR    = 3'd1,
      S_WAIT_CALIB  = 3'd2,
      S_HOLD_PERIPH = 3'd3,
      S_HOLD_CORE   = 3'd4,
      S_RUN         = 3'd5,
      S_FAIL        = 3'd6
   } state_t;

   localparam int RETRY_W = $clog2(MAX_RETRY + 2);
`else
   typedef enum logic [2:0] {
      S_WAIT_LOCK   = 3'd0,
      S_HOLD_DDR    = 3'd1,
      S_WAIT_CALIB  = 3'd2,
      S_HOLD_PERIPH = 3'd3,
      S_HOLD_CORE   = 3'd4,
      S_RUN         = 3'd5
   } state_t;
`endif

   if (HOLD_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_W) ||
       CALIB_TIMEOUT < 1 || CALIB_TIMEOUT >= (1 << CNT_W) || MAX_RETRY < 0) begin : g_param_err
      $error("reset_sequencer: illegal parameter combination");
   end

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             lock_ok;
   logic             hold_done;
   logic             ack_q, ack_nxt;
   logic             ddr_q, ddr_nxt;
   logic             per_q, per_nxt;
   logic             core_q, core_nxt;
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
   logic [RETRY_W-1:0] retry;
   logic               retry_inc;
   logic               fail_q, fail_nxt;
`endif

   assign lock_ok   = (bus.pll_lock == 2'b11);
   assign hold_done = (cnt == CNT_W'(HOLD_CYCLES - 1));

   // Next-state decode; lock loss dominates everything except the RUN software request, which also acks.
   always_comb begin
      state_nxt = state;
      ack_nxt   = 1'b0;
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
      retry_inc = 1'b0;
`endif
      case (state)
         S_WAIT_LOCK: begin
            if (lock_ok) state_nxt = S_HOLD_DDR;
         end
         S_HOLD_DDR: begin
            if (!lock_ok)       state_nxt = S_WAIT_LOCK;
            else if (hold_done) state_nxt = S_WAIT_CALIB;
         end
         S_WAIT_CALIB: begin
            if (!lock_ok)                state_nxt = S_WAIT_LOCK;
            else if (bus.ddr_calib_done) state_nxt = S_HOLD_PERIPH;
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
            else if (cnt == CNT_W'(CALIB_TIMEOUT - 1)) begin
               if (retry == RETRY_W'(MAX_RETRY)) begin
                  state_nxt = S_FAIL;
               end else begin
                  state_nxt = S_HOLD_DDR;
                  retry_inc = 1'b1;
               end
            end
`endif
         end
         S_HOLD_PERIPH: begin
            if (!lock_ok)                 state_nxt = S_WAIT_LOCK;
            else if (!bus.ddr_calib_done) state_nxt = S_WAIT_CALIB;
            else if (hold_done)           state_nxt = S_HOLD_CORE;
         end
         S_HOLD_CORE: begin
            if (!lock_ok)                 state_nxt = S_WAIT_LOCK;
            else if (!bus.ddr_calib_done) state_nxt = S_WAIT_CALIB;
            else if (hold_done)           state_nxt = S_RUN;
         end
         S_RUN: begin
            if (bus.sw_rst_req) begin
               state_nxt = S_WAIT_LOCK;
               ack_nxt   = 1'b1;
            end else if (!lock_ok) begin
               state_nxt = S_WAIT_LOCK;
            end else if (!bus.ddr_calib_done) begin
               state_nxt = S_WAIT_CALIB;
            end
         end
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
         S_FAIL: state_nxt = S_FAIL;
`endif
         default: state_nxt = S_WAIT_LOCK;
      endcase

      // Reset levels are decoded from the next state so they register on the same edge as the state.
      ddr_nxt  = (state_nxt == S_WAIT_LOCK) || (state_nxt == S_HOLD_DDR);
      per_nxt  = (state_nxt != S_HOLD_CORE) && (state_nxt != S_RUN);
      core_nxt = (state_nxt != S_RUN);
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
      ddr_nxt  = ddr_nxt || (state_nxt == S_FAIL);
      fail_nxt = (state_nxt == S_FAIL);
`endif
   end

   // State, stage counter and registered outputs; counter restarts on every state change.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= S_WAIT_LOCK;
         cnt    <= '0;
         ack_q  <= 1'b0;
         ddr_q  <= 1'b1;
         per_q  <= 1'b1;
         core_q <= 1'b1;
      end else begin
         state  <= state_nxt;
         cnt    <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
         ack_q  <= ack_nxt;
         ddr_q  <= ddr_nxt;
         per_q  <= per_nxt;
         core_q <= core_nxt;
      end
   end

`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
   // Retry count and sticky failure flag; only rstn clears them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         retry  <= '0;
         fail_q <= 1'b0;
      end else begin
         if (retry_inc) retry <= retry + RETRY_W'(1);
         fail_q <= fail_nxt;
      end
   end

   assign bus.calib_fail_o = fail_q;
`else
   assign bus.calib_fail_o = 1'b0;
`endif

   assign bus.seq_state_o  = state;
   assign bus.sw_rst_ack   = ack_q;
   assign bus.ddr_rst_o    = ddr_q;
   assign bus.periph_rst_o = per_q;
   assign bus.core_rst_o   = core_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer
module tb_reset_sequencer;
   localparam int H       = 4;
   localparam int TMO     = 20;
   localparam int RETRIES = 2;

   typedef struct {
      int         at;
      string      tag;
      logic [2:0] st;
      logic       ddr;
      logic       per;
      logic       core;
      logic       ack;
      logic       fail;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   reset_sequencer_if rif();

   reset_sequencer #(
      .HOLD_CYCLES   (H),
      .CALIB_TIMEOUT (TMO),
      .MAX_RETRY     (RETRIES),
      .CNT_W         (20)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (rif)
   );

   always #5 clk = ~clk;

   // Edge counter: value seen at a negedge is the index of the preceding posedge.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int at, input string tag, input logic [2:0] st, input logic ddr,
                       input logic per, input logic core, input logic ack, input logic fail);
      exp_t e;
      e.at = at; e.tag = tag; e.st = st; e.ddr = ddr; e.per = per;
      e.core = core; e.ack = ack; e.fail = fail;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"},  32'(rif.seq_state_o),  32'd0);
      check({tag, "_ddr"},    32'(rif.ddr_rst_o),    32'd1);
      check({tag, "_periph"}, 32'(rif.periph_rst_o), 32'd1);
      check({tag, "_core"},   32'(rif.core_rst_o),   32'd1);
      check({tag, "_ack"},    32'(rif.sw_rst_ack),   32'd0);
      check({tag, "_fail"},   32'(rif.calib_fail_o), 32'd0);
   endtask

   // Expected full sequence: HOLD_DDR from e0, HOLD_PERIPH entered at ce.
   task automatic seq_expect(input string tag, input int e0, input int ce);
      push(e0,          {tag, "_hddr"},  3'd1, 1, 1, 1, 0, 0);
      push(e0 + H - 1,  {tag, "_hddrE"}, 3'd1, 1, 1, 1, 0, 0);
      push(e0 + H,      {tag, "_wcal"},  3'd2, 0, 1, 1, 0, 0);
      push(ce - 1,      {tag, "_wcalE"}, 3'd2, 0, 1, 1, 0, 0);
      push(ce,          {tag, "_hper"},  3'd3, 0, 1, 1, 0, 0);
      push(ce + H - 1,  {tag, "_hperE"}, 3'd3, 0, 1, 1, 0, 0);
      push(ce + H,      {tag, "_hcore"}, 3'd4, 0, 0, 1, 0, 0);
      push(ce + 2*H - 1,{tag, "_hcorE"}, 3'd4, 0, 0, 1, 0, 0);
      push(ce + 2*H,    {tag, "_run"},   3'd5, 0, 0, 0, 0, 0);
   endtask

   // One-cycle lock glitch; returns the edge that samples lock again.
   task automatic relock(input string tag, output int e0);
      rif.pll_lock = 2'b01;
      push(cyc + 1, {tag, "_drop"}, 3'd0, 1, 1, 1, 0, 0);
      @(negedge clk);
      rif.pll_lock = 2'b11;
      e0 = cyc + 1;
   endtask

   // Compare every expectation due at this edge; stale ones count as failures.
   always @(negedge clk) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].at == cyc) begin
            check({exp_q[i].tag, "_state"},  32'(rif.seq_state_o),  32'(exp_q[i].st));
            check({exp_q[i].tag, "_ddr"},    32'(rif.ddr_rst_o),    32'(exp_q[i].ddr));
            check({exp_q[i].tag, "_periph"}, 32'(rif.periph_rst_o), 32'(exp_q[i].per));
            check({exp_q[i].tag, "_core"},   32'(rif.core_rst_o),   32'(exp_q[i].core));
            check({exp_q[i].tag, "_ack"},    32'(rif.sw_rst_ack),   32'(exp_q[i].ack));
            check({exp_q[i].tag, "_fail"},   32'(rif.calib_fail_o), 32'(exp_q[i].fail));
            exp_q.delete(i);
         end else if (exp_q[i].at < cyc) begin
            check({exp_q[i].tag, "_stale"}, 32'(cyc), 32'(exp_q[i].at));
            exp_q.delete(i);
         end
      end
   end

   initial begin
      int e0, ce, c, x;
      rstn = 1'b0;
      rif.pll_lock = 2'b00;
      rif.ddr_calib_done = 1'b0;
      rif.sw_rst_req = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      rstn = 1'b1;
      push(cyc + 1, "idle", 3'd0, 1, 1, 1, 0, 0);
      push(cyc + 2, "idle", 3'd0, 1, 1, 1, 0, 0);
      @(negedge clk);
      @(negedge clk);

      // Nominal: calib rises three cycles after ddr release.
      rif.pll_lock = 2'b11;
      e0 = cyc + 1;
      seq_expect("nom", e0, e0 + H + 4);
      wait_until(e0 + H + 3);
      rif.ddr_calib_done = 1'b1;
      wait_until(e0 + 3*H + 6);

      // Lock loss in RUN, then a re-sequence with calibration already done.
      relock("lock", e0);
      seq_expect("lock", e0, e0 + H + 1);
      wait_until(e0 + 3*H + 3);

      // Software request raised in HOLD_CORE, honoured only once RUN is reached.
      relock("sw", e0);
      ce = e0 + H + 1;
      seq_expect("sw", e0, ce);
      push(ce + 2*H + 1, "sw_ack", 3'd0, 1, 1, 1, 1, 0);
      wait_until(ce + H);
      rif.sw_rst_req = 1'b1;
      wait_until(ce + 2*H + 1);
      rif.sw_rst_req = 1'b0;
      e0 = ce + 2*H + 2;
      seq_expect("sw_re", e0, e0 + H + 1);
      push(e0 + 3*H + 4, "sw_single", 3'd5, 0, 0, 0, 0, 0);
      wait_until(e0 + 3*H + 5);

      // Calibration loss in RUN.
      c = cyc;
      rif.ddr_calib_done = 1'b0;
      push(c + 1, "cal_lost", 3'd2, 0, 1, 1, 0, 0);
      @(negedge clk);
      rif.ddr_calib_done = 1'b1;
      push(c + 2,  "cal_hper",  3'd3, 0, 1, 1, 0, 0);
      push(c + 5,  "cal_hperE", 3'd3, 0, 1, 1, 0, 0);
      push(c + 6,  "cal_hcore", 3'd4, 0, 0, 1, 0, 0);
      push(c + 10, "cal_run",   3'd5, 0, 0, 0, 0, 0);
      wait_until(c + 11);

      // Asynchronous reset in the middle of HOLD_PERIPH.
      relock("arst", e0);
      ce = e0 + H + 1;
      push(e0,     "arst_hddr", 3'd1, 1, 1, 1, 0, 0);
      push(e0 + H, "arst_wcal", 3'd2, 0, 1, 1, 0, 0);
      push(ce,     "arst_hper", 3'd3, 0, 1, 1, 0, 0);
      wait_until(ce + 1);
      rstn = 1'b0;
      #1;
      check_reset_vals("arst");
      repeat (2) @(negedge clk);

      rif.ddr_calib_done = 1'b0;
      rstn = 1'b1;
      e0 = cyc + 1;
      x = e0 + H;
`ifdef RESET_SEQ_CALIB_TIMEOUT_EN
      // Calibration never completes: two retries, then permanent failure.
      push(e0, "tmo_hddr", 3'd1, 1, 1, 1, 0, 0);
      push(x,  "tmo_wcal", 3'd2, 0, 1, 1, 0, 0);
      for (int k = 0; k < RETRIES; k++) begin
         push(x + 24*k + 19, "tmo_wcalE", 3'd2, 0, 1, 1, 0, 0);
         push(x + 24*k + 20, "tmo_retry", 3'd1, 1, 1, 1, 0, 0);
         push(x + 24*k + 24, "tmo_rewcal", 3'd2, 0, 1, 1, 0, 0);
      end
      push(x + 67, "tmo_last", 3'd2, 0, 1, 1, 0, 0);
      push(x + 68, "tmo_fail", 3'd6, 1, 1, 1, 0, 1);
      wait_until(x + 70);
      rif.pll_lock = 2'b01;
      push(x + 71, "fail_hold", 3'd6, 1, 1, 1, 0, 1);
      @(negedge clk);
      rif.pll_lock = 2'b11;
      push(x + 72, "fail_hold", 3'd6, 1, 1, 1, 0, 1);
      wait_until(x + 73);
      rstn = 1'b0;
      #1;
      check_reset_vals("fail_clr");
      @(negedge clk);
      rstn = 1'b1;
`else
      // Without timeout support calibration is awaited indefinitely.
      push(x,      "nocal_wcal", 3'd2, 0, 1, 1, 0, 0);
      push(x + 30, "nocal_wait", 3'd2, 0, 1, 1, 0, 0);
      wait_until(x + 31);
`endif

      repeat (3) @(negedge clk);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset controller for the SoC clocking/reset domain. It waits for both PLLs to lock, then releases the DDR controller from reset and waits for DDR calibration. It then releases the peripheral and CPU core resets in order, with a fixed hold interval between stages. It re-sequences on PLL lock loss, DDR calibration loss or a software reset request.

## Interface
- HOLD_CYCLES, 16: cycles each HOLD state lasts; ≥1.
- CALIB_TIMEOUT, 1000000: cycles allowed in S_WAIT_CALIB before a timeout (macro only).
- MAX_RETRY, 3: calibration retries before S_FAIL (macro only).
- CNT_W, 20: stage counter width; HOLD_CYCLES and CALIB_TIMEOUT must be < 2^CNT_W.
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- pll_lock  in  2  PLL lock flags; locked means 2'b11.
- ddr_calib_done  in  1  DDR calibration complete, level.
- sw_rst_req  in  1  software reset request, level, held until ack.
- sw_rst_ack  out  1  one-cycle pulse, request honoured.
- ddr_rst_o  out  1  DDR controller reset, active-high.
- periph_rst_o  out  1  peripheral reset, active-high.
- core_rst_o  out  1  CPU core reset, active-high.
- seq_state_o  out  3  current state encoding.
- calib_fail_o  out  1  calibration failed permanently.

## Operation
- States and encodings:
  - S_WAIT_LOCK=0, S_HOLD_DDR=1, S_WAIT_CALIB=2, S_HOLD_PERIPH=3, S_HOLD_CORE=4, S_RUN=5.
  - S_FAIL=6 exists only when the macro is defined.
- Reset outputs by state:
  - ddr_rst_o=1 in states 0,1,6.
  - periph_rst_o=1 in states 0–3,6.
  - core_rst_o=1 in states 0–4,6.
- Stage counter: cleared on every state entry and incremented each cycle. HOLD states exit when count==HOLD_CYCLES-1.
- Normal transitions:
  - WAIT_LOCK→HOLD_DDR when pll_lock==2'b11.
  - HOLD_DDR→WAIT_CALIB after the hold count.
  - WAIT_CALIB→HOLD_PERIPH when ddr_calib_done=1.
  - HOLD_PERIPH→HOLD_CORE, then HOLD_CORE→RUN, each after the hold count.
- Lock loss: pll_lock!=2'b11 in any state except 0 and 6 → S_WAIT_LOCK. Highest priority.
- Calibration loss: ddr_calib_done=0 in HOLD_PERIPH, HOLD_CORE or RUN → S_WAIT_CALIB. periph and core resets reassert; ddr_rst_o stays 0.
- Software reset:
  - sw_rst_req=1 in S_RUN → S_WAIT_LOCK, and sw_rst_ack pulses on that edge.
  - sw_rst_req is ignored (no ack) in other states.
  - The requester drops req after seeing ack. A req still high on re-entering RUN triggers another cycle.
- Simultaneous events:
  - Lock loss + sw_rst_req in RUN → S_WAIT_LOCK with ack pulsed.
  - Lock loss + calib loss → lock-loss path.
- rstn low at any time:
  - Immediately forces state 0, all resets 1, ack 0, calib_fail_o 0, counters and retry count 0.

## Timing
- Reset values: seq_state_o=0, ddr/periph/core_rst_o=1, sw_rst_ack=0, calib_fail_o=0.
- All outputs are registered and change on the same edge as the state change; no combinational input→output path.
- E0 is the first edge sampling pll_lock==2'b11. With calibration done before ddr release:
  - ddr_rst_o falls at E0+H.
  - periph_rst_o falls at E0+2H+1.
  - core_rst_o falls at E0+3H+1.
- S_WAIT_CALIB lasts at least 1 cycle.
- Any reassertion (lock loss, calib loss, sw request) occurs on the first edge that samples the event.

## Configuration
- RESET_SEQ_CALIB_TIMEOUT_EN defined — timeout and retry:
  - Reaching count==CALIB_TIMEOUT-1 in S_WAIT_CALIB without calib done → S_HOLD_DDR (ddr_rst_o reasserts), and the retry count increments.
  - A timeout with retry count==MAX_RETRY → S_FAIL, calib_fail_o=1, all resets held.
  - S_FAIL exits only via rstn; lock loss is ignored there.
- RESET_SEQ_CALIB_TIMEOUT_EN undefined:
  - S_WAIT_CALIB waits indefinitely.
  - No S_FAIL state and no retry counter.
  - calib_fail_o tied 0.

## Test plan
Bench parameters: H=4, CALIB_TIMEOUT=20, MAX_RETRY=2.
- Nominal: locks high from edge 1, calib rises 3 cycles after ddr release → ddr_rst_o falls at E0+4; periph_rst_o falls 3+1+4 cycles later; core_rst_o falls 4 cycles after periph; state 5.
- Lock loss: pll_lock=2'b01 for 1 cycle in RUN → next edge state 0 and all resets 1; full re-sequence with identical spacing.
- Software reset:
  - sw_rst_req in HOLD_CORE → no ack.
  - Same req held into RUN → ack pulse 1 cycle, all resets 1 on that edge.
  - Req dropped → single re-sequence.
- Calib loss: ddr_calib_done=0 in RUN → state 2, periph/core resets 1, ddr_rst_o 0; calib back → periph falls after 1+4 cycles.
- Timeout (macro): calib never asserts → ddr_rst_o reasserts every 20 cycles in state 2. On the 3rd timeout → state 6, calib_fail_o=1; pulsing rstn clears it.
- Async reset: rstn low mid HOLD_PERIPH → all outputs at reset values before the next edge.
